// File: rtl/uart_rx_ram_loader.sv
// Serial-to-RAM loader: drains the UART rx FIFO into the character RAM after a
// Start pulse, stopping on the terminator character or when the RAM is full.
module uart_rx_ram_loader #(
    parameter int unsigned AddressBits = 7,
    parameter int unsigned MemorySize  = 80,
    parameter logic [6:0]  Terminator  = 7'h0D
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   Start,
    input  logic                   rx_data_present,
    input  logic [7:0]             rx_data,
    output logic                   read_from_uart,
    output logic                   ram_write,
    output logic [AddressBits-1:0] ram_address,
    output logic [6:0]             ram_data,
    output logic                   Loading,
    output logic                   Done,
    output logic                   Full,
    output logic [AddressBits-1:0] Count
);

    localparam logic [AddressBits-1:0] LastAddr = AddressBits'(MemorySize - 1);
    localparam logic [AddressBits-1:0] AddrOne  = AddressBits'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_ADVANCE,
        S_FINISH
    } state_t;

    state_t                 state;
    logic [AddressBits-1:0] pointer;

    // Only 7-bit characters are stored; the FIFO's top bit is dropped.
    logic unused_rx_msb;
    assign unused_rx_msb = rx_data[7];

    // Load sequencer; pulses default low so every strobe lasts one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            pointer        <= '0;
            read_from_uart <= 1'b0;
            ram_write      <= 1'b0;
            ram_address    <= '0;
            ram_data       <= '0;
            Loading        <= 1'b0;
            Done           <= 1'b0;
            Full           <= 1'b0;
            Count          <= '0;
        end else begin
            read_from_uart <= 1'b0;
            ram_write      <= 1'b0;
            if (Start) begin
                // Arms or restarts; a byte latched in CHECK is dropped here.
                pointer <= '0;
                Count   <= '0;
                Done    <= 1'b0;
                Full    <= 1'b0;
                Loading <= 1'b1;
                state   <= S_WAIT;
            end else begin
                case (state)
                    S_IDLE: state <= S_IDLE;
                    S_WAIT: begin
                        if (rx_data_present) begin
                            read_from_uart <= 1'b1;
                            ram_data       <= rx_data[6:0];
                            state          <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (ram_data == Terminator) begin
                            Full  <= 1'b0;
                            state <= S_FINISH;
                        end else begin
                            ram_write   <= 1'b1;
                            ram_address <= pointer;
                            state       <= S_ADVANCE;
                        end
                    end
                    S_ADVANCE: begin
                        pointer <= pointer + AddrOne;
                        Count   <= Count + AddrOne;
                        if (pointer == LastAddr) begin
                            Full  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                    S_FINISH: begin
                        Loading <= 1'b0;
                        Done    <= 1'b1;
                        state   <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
